// File: rtl/cache_adaptor_pkg.sv
// Shared types and default geometry for the cache-line to memory-burst adaptor.
package cache_adaptor_pkg;

    localparam int DEFAULT_LINE_W  = 256;
    localparam int DEFAULT_BURST_W = 64;
    localparam int DEFAULT_ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_e;

endpackage

// File: rtl/burst_beat_counter.sv
// Wrapping beat index counter; remembers its load value so the last beat is
// the one just before wrapping back to where the burst started.
module burst_beat_counter #(
    parameter  int BEATS = 4,
    localparam int IDX_W = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [IDX_W-1:0] load_val,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] start_r;
    logic [IDX_W-1:0] next_idx_s;

    assign next_idx_s = idx + IDX_W'(1);
    assign last       = (next_idx_s == start_r);

    // Index register: load sets the start slot, enable advances modulo BEATS
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx     <= '0;
            start_r <= '0;
        end else if (load) begin
            idx     <= load_val;
            start_r <= load_val;
        end else if (en) begin
            idx     <= next_idx_s;
        end
    end

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Splits LLC line fills/write-backs into BEATS memory beats.
// Optional macro CACHELINE_ADAPTOR_CWF_EN: critical-word-first read fills.
module cacheline_burst_adaptor
    import cache_adaptor_pkg::*;
#(
    parameter int LINE_W  = DEFAULT_LINE_W,
    parameter int BURST_W = DEFAULT_BURST_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int BEATS    = LINE_W / BURST_W;
    localparam int IDX_W    = $clog2(BEATS);
    localparam int BEAT_OFF = $clog2(BURST_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
    localparam logic [ADDR_W-1:0] BEAT_MASK = ~ADDR_W'(BURST_W / 8 - 1);

    adaptor_state_e    state_r;
    logic [LINE_W-1:0] line_buf_r;
    logic              cnt_load_s;
    logic [IDX_W-1:0]  cnt_load_val_s;
    logic              cnt_en_s;
    logic [IDX_W-1:0]  idx_s;
    logic [IDX_W-1:0]  next_idx_s;
    logic              last_s;
    logic [IDX_W-1:0]  start_slot_s;
    logic [ADDR_W-1:0] line_addr_s;
    logic [ADDR_W-1:0] beat_addr_s;
    logic [ADDR_W-1:0] rd_addr_s;

    assign line_addr_s = address_i & LINE_MASK;
    assign beat_addr_s = address_i & BEAT_MASK;
    assign next_idx_s  = idx_s + IDX_W'(1);

`ifdef CACHELINE_ADAPTOR_CWF_EN
    assign start_slot_s = beat_addr_s[BEAT_OFF +: IDX_W];
    assign rd_addr_s    = beat_addr_s;
`else
    assign start_slot_s = IDX_W'(0);
    assign rd_addr_s    = (beat_addr_s & line_addr_s);
`endif

    burst_beat_counter #(
        .BEATS (BEATS)
    ) u_beat_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .en       (cnt_en_s),
        .idx      (idx_s),
        .last     (last_s)
    );

    // Beat counter control: load the start slot on acceptance, count acked beats
    always_comb begin
        cnt_load_s     = 1'b0;
        cnt_load_val_s = IDX_W'(0);
        cnt_en_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (write_i) begin
                    cnt_load_s = 1'b1;
                end else if (read_i) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = start_slot_s;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            READ, WRITE: cnt_en_s = resp_i;
            DONE:        cnt_en_s = 1'b0;
            default:     cnt_en_s = 1'b0;
        endcase
    end

    // Main FSM with all LLC- and memory-facing outputs registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            line_buf_r <= '0;
            line_o     <= '0;
            burst_o    <= '0;
            address_o  <= '0;
            read_o     <= 1'b0;
            write_o    <= 1'b0;
            resp_o     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_o <= 1'b0;
                    if (write_i) begin
                        state_r    <= WRITE;
                        write_o    <= 1'b1;
                        address_o  <= line_addr_s;
                        line_buf_r <= line_i;
                        burst_o    <= line_i[BURST_W-1:0];
                    end else if (read_i) begin
                        state_r   <= READ;
                        read_o    <= 1'b1;
                        address_o <= rd_addr_s;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[idx_s*BURST_W +: BURST_W] <= burst_i;
                        if (last_s) begin
                            read_o  <= 1'b0;
                            resp_o  <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        if (last_s) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            burst_o <= line_buf_r[next_idx_s*BURST_W +: BURST_W];
                        end
                    end
                end
                DONE: begin
                    resp_o  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
